dma_ctl: RTL and testbench
==========================

# dma_ctl

Word-copy DMA controller that shares the CPU's single data-memory port. It sits between the CPU's M-stage data port and the DM/IO bridge. The CPU always owns the port when it makes an access. In every other cycle the DMA engine steals the port to move one word, either a read or a write. The engine is configured through four memory-mapped registers and raises an interrupt line (fed into `int[5:0]`) on completion.

## Interface
- `BASE`, default 32'h0000_7F20: base of the 16-byte register window.
- `LW`, default 16: width of the length counter, in words.

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `cpu_act`  in  1  CPU M stage performs a data access (load or store) this cycle
- `cpu_we`  in  1  CPU store strobe (`dwe`)
- `cpu_em`  in  2  CPU access mode: 0 word, 1 byte, 2 half
- `cpu_a`  in  32  CPU data address
- `cpu_wd`  in  32  CPU store data
- `cpu_rd`  out  32  read data to CPU: register value on `hit`, else `mem_rd`
- `hit`  out  1  `cpu_a[31:4] == BASE[31:4]`; combinational
- `mem_we`  out  1  write strobe to DM/bridge
- `mem_em`  out  2  access mode to DM/bridge
- `mem_a`  out  32  address to DM/bridge
- `mem_wd`  out  32  write data to DM/bridge
- `mem_rd`  in  32  combinational read data from DM/bridge
- `irq`  out  1  `done & ie`, registered

## Operation
- Registers (offset from BASE). Word writes only take effect (`cpu_act & cpu_we & hit & cpu_em==0`); sub-word writes are ignored.
  - 0x0 SRC: bits [1:0] are forced to 0 on write. Reads return the live source pointer.
  - 0x4 DST: same rules as SRC.
  - 0x8 LEN: bits [LW-1:0]. Reads return the remaining word count, zero-extended.
  - 0xC CTRL, read view: bit1 busy, bit2 done, bit3 ie; all other bits read 0.
  - 0xC CTRL, write bits: bit0 start (W1), bit2 done (W1C), bit3 ie (RW), bit4 abort (W1).
- While busy, writes to SRC, DST and LEN are ignored. A start written while busy is ignored.
- Bus ownership:
  - The port is free when `!cpu_act || hit`.
  - When the CPU owns the port, `mem_*` passes through the `cpu_*` values.
  - When the port is free and the FSM is in RD or WR, `mem_*` carries the DMA access with `mem_em=0`.
  - Otherwise `mem_we=0`.
- FSM states: IDLE, RD, WR.
  - IDLE, start written with LEN≠0: go to RD, set busy, clear done.
  - IDLE, start written with LEN==0: stay in IDLE and set done in the same edge.
  - RD, port free: `mem_a=SRC`. At the edge, `buf<=mem_rd`, `SRC+=4`, go to WR.
  - RD, port not free: hold.
  - WR, port free: `mem_we=1`, `mem_a=DST`, `mem_wd=buf`. At the edge, `DST+=4`, `LEN-=1`. If LEN was 1, go to IDLE, clear busy, set done. Otherwise go to RD.
  - WR, port not free: hold; `buf` is preserved.
  - Abort in any state: go to IDLE and clear busy. done is unchanged. SRC, DST and LEN keep their current values.
  - Simultaneous start and abort: abort wins.
- Pointer arithmetic: address increments are mod 2^32 and wrap silently.
- Simultaneous events:
  - A W1C of done in the same cycle as completion: done ends up set (set wins).
  - A start write with done=1: done is cleared.

## Timing
- Reset values:
  - SRC, DST, LEN, buf, done, ie, busy: all 0.
  - FSM state: IDLE.
  - `irq` = 0; `mem_we` = `cpu_act & cpu_we & ~hit`.
- A reset asserted mid-transfer aborts on the next edge. The partial copy is left in memory.
- `hit`, `cpu_rd` and `mem_*` are combinational within the cycle, matching the single-cycle DM read path.
- Start is written at edge T0. The first DMA read occurs in cycle T0+1.
- With the port always free, N words take exactly 2N cycles. The last write is in cycle T0+2N. done and `irq` are visible from cycle T0+2N+1.
- Every CPU-owned cycle delays the engine by exactly one cycle. The engine never stalls the CPU.
- `irq` = registered `done & ie`, updated on the same edge as done and ie.

## Test plan
- Copy with port idle:
  - Preload DM[0x100..0x10C] = 1,2,3,4. Write SRC=0x100, DST=0x200, LEN=4, CTRL=0x9.
  - Required: DM[0x200..0x20C] = 1,2,3,4 after 8 cycles.
  - Required: CTRL reads 0xC; `irq`=1 on cycle 9.
- Interleaved CPU traffic:
  - Run the same copy with `cpu_act` asserted every other cycle.
  - Required: completion at 16 cycles.
  - Required: every CPU store reaches memory unmodified; no DMA strobe in CPU-owned cycles.
- Configuration edge cases:
  - Start with LEN=0: done=1 next cycle, no memory strobes.
  - Unaligned SRC=0x103: reads back as 0x100.
  - Byte write to LEN: LEN is unchanged.
- Abort:
  - Abort at cycle 3 of a 4-word copy.
  - Required: busy=0, done=0, LEN reads 3, only DM[0x200] written.
- Reset mid-transfer:
  - Assert `reset` during WR.
  - Required: all registers read 0 and `irq`=0 the next cycle; no further strobes.
- Wrap:
  - SRC=0xFFFF_FFFC, LEN=2.
  - Required: the second read is from address 0x0000_0000.

Source files
------------

// File: rtl/dma_ctl.sv
// Word-copy DMA engine that borrows the CPU's data-memory port whenever the CPU is not using it.
// Four memory-mapped registers (SRC, DST, LEN, CTRL) sit in a 16-byte window at BASE.
module dma_ctl #(
  parameter logic [31:0] BASE = 32'h0000_7F20,
  parameter int unsigned LW   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_act,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_em,
  input  logic [31:0] cpu_a,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        hit,
  output logic        mem_we,
  output logic [1:0]  mem_em,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   src_q, src_d;
  logic [31:0]   dst_q, dst_d;
  logic [31:0]   buf_q, buf_d;
  logic [LW-1:0] len_q, len_d;
  logic          done_q, done_d;
  logic          ie_q, ie_d;
  logic          irq_q, irq_d;

  logic          port_free;
  logic          reg_we;
  logic          wr_src, wr_dst, wr_len, wr_ctrl;
  logic          start, abort, busy;
  logic          done_w1c;
  logic [31:0]   len_ext;

  assign hit       = (cpu_a[31:4] == BASE[31:4]);
  assign port_free = ~cpu_act | hit;
  assign reg_we    = cpu_act & cpu_we & hit & (cpu_em == 2'd0);
  assign wr_src    = reg_we & (cpu_a[3:2] == 2'd0);
  assign wr_dst    = reg_we & (cpu_a[3:2] == 2'd1);
  assign wr_len    = reg_we & (cpu_a[3:2] == 2'd2);
  assign wr_ctrl   = reg_we & (cpu_a[3:2] == 2'd3);
  assign abort     = wr_ctrl & cpu_wd[4];
  assign start     = wr_ctrl & cpu_wd[0] & ~cpu_wd[4];
  assign busy      = (state_q != S_IDLE);
  assign len_ext   = 32'(len_q);
  assign irq       = irq_q;

  // Register read mux; memory data passes through outside the window.
  always_comb begin
    cpu_rd = mem_rd;
    if (hit) begin
      case (cpu_a[3:2])
        2'd0:    cpu_rd = src_q;
        2'd1:    cpu_rd = dst_q;
        2'd2:    cpu_rd = len_ext;
        2'd3:    cpu_rd = {28'h000_0000, ie_q, done_q, busy, 1'b0};
        default: cpu_rd = 32'h0000_0000;
      endcase
    end else begin
      cpu_rd = mem_rd;
    end
  end

  // Port arbitration: the CPU always wins, the engine only uses free cycles.
  always_comb begin
    mem_we = 1'b0;
    mem_em = cpu_em;
    mem_a  = cpu_a;
    mem_wd = cpu_wd;
    if (!port_free) begin
      mem_we = cpu_we;
    end else if (state_q == S_RD) begin
      mem_em = 2'd0;
      mem_a  = src_q;
    end else if (state_q == S_WR) begin
      mem_we = 1'b1;
      mem_em = 2'd0;
      mem_a  = dst_q;
      mem_wd = buf_q;
    end else begin
      mem_we = 1'b0;
    end
  end

  // Next-state logic for the copy FSM and its configuration registers.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    buf_d    = buf_q;
    ie_d     = ie_q;
    done_w1c = done_q & ~(wr_ctrl & cpu_wd[2]);
    done_d   = done_w1c;

    if (wr_ctrl) begin
      ie_d = cpu_wd[3];
    end else begin
      ie_d = ie_q;
    end

    if (!busy) begin
      if (wr_src) begin
        src_d = {cpu_wd[31:2], 2'b00};
      end else if (wr_dst) begin
        dst_d = {cpu_wd[31:2], 2'b00};
      end else if (wr_len) begin
        len_d = cpu_wd[LW-1:0];
      end else begin
        len_d = len_q;
      end
    end else begin
      len_d = len_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start && (len_q != {LW{1'b0}})) begin
          state_d = S_RD;
          done_d  = 1'b0;
        end else if (start) begin
          done_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (port_free) begin
          buf_d   = mem_rd;
          src_d   = src_q + 32'd4;
          state_d = S_WR;
        end else begin
          state_d = S_RD;
        end
      end
      S_WR: begin
        if (port_free) begin
          dst_d = dst_q + 32'd4;
          len_d = len_q - {{(LW-1){1'b0}}, 1'b1};
          if (len_q == {{(LW-1){1'b0}}, 1'b1}) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RD;
          end
        end else begin
          state_d = S_WR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort freezes pointers and count where they are and leaves done alone.
    if (abort) begin
      state_d = S_IDLE;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      buf_d   = buf_q;
      done_d  = done_w1c;
    end else begin
      buf_d = buf_d;
    end

    irq_d = done_d & ie_d;
  end

  // State and register storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= 32'h0000_0000;
      dst_q   <= 32'h0000_0000;
      buf_q   <= 32'h0000_0000;
      len_q   <= {LW{1'b0}};
      done_q  <= 1'b0;
      ie_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      done_q  <= done_d;
      ie_q    <= ie_d;
      irq_q   <= irq_d;
    end
  end

endmodule

// File: tb/tb_dma_ctl.sv
// Scoreboard bench for dma_ctl: stimulus queues expected memory writes and register reads,
// a negedge monitor pops and compares them; a shadow memory predicts the final image.
module tb_dma_ctl;

  localparam logic [31:0] BASE = 32'h0000_7F20;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_act, cpu_we;
  logic [1:0]  cpu_em;
  logic [31:0] cpu_a, cpu_wd, cpu_rd;
  logic        hit, mem_we;
  logic [1:0]  mem_em;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        irq;

  always #5 clk = ~clk;

  dma_ctl #(.BASE(BASE), .LW(16)) dut (
    .clk(clk), .reset(reset), .cpu_act(cpu_act), .cpu_we(cpu_we), .cpu_em(cpu_em),
    .cpu_a(cpu_a), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .hit(hit), .mem_we(mem_we),
    .mem_em(mem_em), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd), .irq(irq)
  );

  // Data memory: 4 KB, aliased on address bits [11:2]
  logic [31:0] dm      [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_idx;
  logic [31:0] pre_d;

  assign mem_rd = dm[mem_a[11:2]];

  always @(posedge clk) begin
    if (pre_we) dm[pre_idx] <= pre_d;
    else if (mem_we) dm[mem_a[11:2]] <= mem_wd;
  end

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         dma_q[$];
  wr_t         cpu_q[$];
  logic [31:0] rd_q[$];
  wr_t         mon_e;
  logic [31:0] mon_r;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction

  // Monitor: every strobe and every register read is matched against the scoreboard
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (cpu_act && !hit) begin
        if (cpu_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cpu_store_unexpected: strobe at %h, required none", mem_a);
        end else begin
          mon_e = cpu_q.pop_front();
          chk("cpu_store_addr", mem_a, mon_e.a);
          chk("cpu_store_data", mem_wd, mon_e.d);
        end
      end else begin
        if (dma_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dma_write_unexpected: strobe at %h, required none", mem_a);
        end else begin
          mon_e = dma_q.pop_front();
          chk("dma_write_addr", mem_a, mon_e.a);
          chk("dma_write_data", mem_wd, mon_e.d);
          chk("dma_write_em", 32'(mem_em), 32'd0);
        end
      end
    end
    if (cpu_act && !cpu_we && hit) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL reg_read_unexpected: read %h, required none", cpu_rd);
      end else begin
        mon_r = rd_q.pop_front();
        chk("reg_read", cpu_rd, mon_r);
      end
    end
  end

  task automatic bus(input logic we, input logic [1:0] em, input logic [31:0] a, input logic [31:0] wd);
    cpu_act = 1'b1; cpu_we = we; cpu_em = em; cpu_a = a; cpu_wd = wd;
    @(posedge clk); #1;
    cpu_act = 1'b0; cpu_we = 1'b0; cpu_em = 2'd0; cpu_a = 32'd0; cpu_wd = 32'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wreg(input logic [31:0] off, input logic [31:0] v);
    bus(1'b1, 2'd0, BASE + off, v);
  endtask

  task automatic rreg(input logic [31:0] off, input logic [31:0] exp);
    rd_q.push_back(exp);
    bus(1'b0, 2'd0, BASE + off, 32'd0);
  endtask

  task automatic cpu_store(input logic [31:0] a, input logic [31:0] d);
    cpu_q.push_back('{a: a, d: d});
    ref_mem[a[11:2]] = d;
    bus(1'b1, 2'd0, a, d);
  endtask

  // Reference copy: word i goes from src+4i to dst+4i, addresses wrapping mod 2^32
  task automatic plan_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
    logic [31:0] as, ad, d;
    for (int i = 0; i < n; i++) begin
      as = src + 32'(4 * i);
      ad = dst + 32'(4 * i);
      d  = ref_mem[as[11:2]];
      dma_q.push_back('{a: ad, d: d});
      ref_mem[ad[11:2]] = d;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, s, n, bad;
    logic [31:0] src, dst;
    reset = 1'b1; cpu_act = 1'b0; cpu_we = 1'b0; cpu_em = 2'd0; cpu_a = 32'd0; cpu_wd = 32'd0;
    pre_we = 1'b0; pre_idx = 10'd0; pre_d = 32'd0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
    for (int i = 0; i < 4; i++) ref_mem[10'h40 + 10'(i)] = 32'(i + 1);
    @(posedge clk); #1;
    for (int i = 0; i < 1024; i++) begin
      pre_we = 1'b1; pre_idx = 10'(i); pre_d = ref_mem[i];
      @(posedge clk); #1;
    end
    pre_we = 1'b0;
    idle(1);
    reset = 1'b0;

    // Reset state
    chk("reset_irq", 32'(irq), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    rreg(32'h0, 32'h0); rreg(32'h4, 32'h0); rreg(32'h8, 32'h0); rreg(32'hC, 32'h0);

    // Copy with the port idle
    wreg(32'h0, 32'h100); wreg(32'h4, 32'h200); wreg(32'h8, 32'd4);
    plan_copy(32'h100, 32'h200, 4);
    wreg(32'hC, 32'h9);
    idle(7);
    chk("idle_copy_irq_early", 32'(irq), 32'd0);
    idle(1);
    chk("idle_copy_irq", 32'(irq), 32'd1);
    for (int i = 0; i < 4; i++) chk("idle_copy_dm", dm[10'h80 + 10'(i)], 32'(i + 1));
    rreg(32'hC, 32'hC);

    // Copy with CPU stores every other cycle
    wreg(32'h0, 32'h100); wreg(32'h4, 32'h280); wreg(32'h8, 32'd4);
    plan_copy(32'h100, 32'h280, 4);
    wreg(32'hC, 32'h9);
    for (int k = 1; k <= 15; k++) begin
      if (k % 2 == 1) cpu_store(32'h300 + 32'(4 * (k / 2)), $urandom);
      else idle(1);
    end
    chk("interleave_irq_early", 32'(irq), 32'd0);
    idle(1);
    chk("interleave_irq", 32'(irq), 32'd1);
    chk("interleave_dma_q_empty", 32'(dma_q.size()), 32'd0);

    // Configuration edge cases
    wreg(32'hC, 32'hC);
    chk("w1c_done_irq", 32'(irq), 32'd0);
    wreg(32'hC, 32'h9);
    chk("len0_irq", 32'(irq), 32'd1);
    rreg(32'hC, 32'hC);
    rreg(32'h8, 32'h0);
    wreg(32'h0, 32'h103);
    rreg(32'h0, 32'h100);
    wreg(32'h8, 32'd5);
    bus(1'b1, 2'd1, BASE + 32'h8, 32'd9);
    bus(1'b1, 2'd2, BASE + 32'h8, 32'd7);
    rreg(32'h8, 32'd5);

    // Abort in cycle 3 of a 4-word copy
    wreg(32'h0, 32'h100); wreg(32'h4, 32'h200); wreg(32'h8, 32'd4);
    plan_copy(32'h100, 32'h200, 1);
    wreg(32'hC, 32'h9);
    idle(2);
    wreg(32'hC, 32'h18);
    rreg(32'hC, 32'h8);
    rreg(32'h8, 32'd3);
    rreg(32'h0, 32'h104);
    rreg(32'h4, 32'h204);
    idle(4);
    chk("abort_dma_q_empty", 32'(dma_q.size()), 32'd0);

    // Reset during the first write
    wreg(32'h0, 32'h100); wreg(32'h4, 32'h240); wreg(32'h8, 32'd4);
    plan_copy(32'h100, 32'h240, 1);
    wreg(32'hC, 32'h9);
    idle(1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("midreset_irq", 32'(irq), 32'd0);
    rreg(32'h0, 32'h0); rreg(32'h4, 32'h0); rreg(32'h8, 32'h0); rreg(32'hC, 32'h0);
    idle(6);
    chk("midreset_dma_q_empty", 32'(dma_q.size()), 32'd0);

    // Source pointer wraps past the top of the address space
    wreg(32'h0, 32'hFFFF_FFFC); wreg(32'h4, 32'h400); wreg(32'h8, 32'd2);
    plan_copy(32'hFFFF_FFFC, 32'h400, 2);
    wreg(32'hC, 32'h9);
    chk("wrap_first_read_addr", mem_a, 32'hFFFF_FFFC);
    idle(2);
    chk("wrap_second_read_addr", mem_a, 32'h0000_0000);
    chk("wrap_second_read_we", 32'(mem_we), 32'd0);
    idle(2);
    chk("wrap_irq", 32'(irq), 32'd1);
    rreg(32'h0, 32'h4);

    // Random copies under random CPU traffic; each stolen cycle costs exactly one cycle
    for (int t = 0; t < 6; t++) begin
      src = 32'h800 + 32'(4 * $urandom_range(0, 15));
      dst = 32'hA00 + 32'(4 * $urandom_range(0, 15));
      n   = $urandom_range(1, 6);
      wreg(32'h0, src); wreg(32'h4, dst); wreg(32'h8, 32'(n));
      plan_copy(src, dst, n);
      wreg(32'hC, 32'h9);
      c = 1; s = 0;
      while (c <= 300 && irq !== 1'b1) begin
        if ($urandom_range(0, 2) == 0) begin
          cpu_store(32'h300 + 32'(4 * $urandom_range(0, 15)), $urandom);
          s++;
        end else begin
          idle(1);
        end
        c++;
      end
      chk("rand_done_cycle", 32'(c), 32'(2 * n + s + 1));
      chk("rand_dma_q_empty", 32'(dma_q.size()), 32'd0);
    end

    idle(3);
    chk("final_cpu_q_empty", 32'(cpu_q.size()), 32'd0);
    chk("final_rd_q_empty", 32'(rd_q.size()), 32'd0);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (dm[i] !== ref_mem[i]) bad++;
    chk("final_mem_image", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
